// File: rtl/timer_sequencer.sv
// Avalon-MM master that drives the interval timer's register port: programs and starts
// the timer, services its timeout IRQ as clean tick pulses, stops it and captures counter snapshots.
module timer_sequencer #(
  parameter logic CONTINUOUS = 1'b1,
  parameter logic IRQ_EN     = 1'b1,
  parameter int   TICK_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_req,
  input  logic [31:0]       period,
  input  logic              stop_req,
  input  logic              snap_req,
  output logic              busy,
  output logic              running,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic              snap_valid,
  output logic [31:0]       snap_value,
  output logic [2:0]        tmr_address,
  output logic              tmr_chipselect,
  output logic              tmr_write_n,
  output logic [15:0]       tmr_writedata,
  input  logic [15:0]       tmr_readdata,
  input  logic              tmr_irq
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_PL,
    S_WR_PH,
    S_WR_CTRL,
    S_RUN,
    S_CLR_ST,
    S_STOP_WR,
    S_STOP_CLR,
    S_SNAP_WR,
    S_SNAP_RL,
    S_SNAP_RH,
    S_SNAP_DONE
  } state_t;

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_PERIODL = 3'd2;
  localparam logic [2:0] ADDR_PERIODH = 3'd3;
  localparam logic [2:0] ADDR_SNAPL   = 3'd4;
  localparam logic [2:0] ADDR_SNAPH   = 3'd5;

  state_t      state;
  state_t      state_next;
  logic [31:0] period_q;
  logic        load_period;
  logic        from_run;
  logic        programming;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      period_q   <= 32'd0;
      from_run   <= 1'b0;
      tick_count <= '0;
      snap_valid <= 1'b0;
      snap_value <= 32'd0;
    end else begin
      state      <= state_next;
      snap_valid <= (state == S_SNAP_DONE);
      if (load_period) begin
        period_q <= period;
      end
      // Remember where a sequence was launched from so a snapshot returns there.
      if (state == S_IDLE || state == S_RUN) begin
        from_run <= (state == S_RUN);
      end
      case (state)
        S_WR_CTRL:   tick_count <= '0;
        S_CLR_ST:    tick_count <= tick_count + TICK_W'(1);
        S_SNAP_RH:   snap_value[15:0]  <= tmr_readdata;
        S_SNAP_DONE: snap_value[31:16] <= tmr_readdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next     = state;
    load_period    = 1'b0;
    tick           = 1'b0;
    tmr_address    = 3'd0;
    tmr_chipselect = 1'b0;
    tmr_write_n    = 1'b1;
    tmr_writedata  = 16'd0;
    case (state)
      S_IDLE: begin
        if (start_req) begin
          load_period = 1'b1;
          state_next  = S_WR_PL;
        end else if (snap_req) begin
          state_next = S_SNAP_WR;
        end
      end
      S_WR_PL: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = ADDR_PERIODL;
        tmr_writedata  = period_q[15:0];
        state_next     = S_WR_PH;
      end
      S_WR_PH: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = ADDR_PERIODH;
        tmr_writedata  = period_q[31:16];
        state_next     = S_WR_CTRL;
      end
      S_WR_CTRL: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = ADDR_CONTROL;
        tmr_writedata  = {12'd0, 1'b0, 1'b1, CONTINUOUS, IRQ_EN};
        state_next     = S_RUN;
      end
      S_RUN: begin
        if (stop_req) begin
          state_next = S_STOP_WR;
        end else if (tmr_irq) begin
          state_next = S_CLR_ST;
        end else if (start_req) begin
          load_period = 1'b1;
          state_next  = S_WR_PL;
        end else if (snap_req) begin
          state_next = S_SNAP_WR;
        end
      end
      S_CLR_ST: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = ADDR_STATUS;
        tick           = 1'b1;
        state_next     = S_RUN;
      end
      S_STOP_WR: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = ADDR_CONTROL;
        tmr_writedata  = 16'h0008;
        state_next     = S_STOP_CLR;
      end
      // Clearing status here drops a timeout that raced the stop, so it never becomes a tick.
      S_STOP_CLR: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = ADDR_STATUS;
        state_next     = S_IDLE;
      end
      S_SNAP_WR: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = ADDR_SNAPL;
        state_next     = S_SNAP_RL;
      end
      S_SNAP_RL: begin
        tmr_chipselect = 1'b1;
        tmr_address    = ADDR_SNAPL;
        state_next     = S_SNAP_RH;
      end
      S_SNAP_RH: begin
        tmr_chipselect = 1'b1;
        tmr_address    = ADDR_SNAPH;
        state_next     = S_SNAP_DONE;
      end
      S_SNAP_DONE: begin
        state_next = from_run ? S_RUN : S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Reprogramming stops the timer, so those states do not count as running.
  assign programming = (state == S_WR_PL) || (state == S_WR_PH) || (state == S_WR_CTRL);
  assign busy        = (state != S_IDLE) && (state != S_RUN);
  assign running     = (state == S_RUN) || (busy && from_run && !programming);

endmodule

// File: tb/tb_timer_sequencer.sv
// Directed bench for timer_sequencer with a behavioural interval-timer model on the bus.
module tb_timer_sequencer;

  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start_req = 1'b0;
  logic [31:0]   period = 32'd0;
  logic          stop_req = 1'b0;
  logic          snap_req = 1'b0;
  logic          busy;
  logic          running;
  logic          tick;
  logic [TW-1:0] tick_count;
  logic          snap_valid;
  logic [31:0]   snap_value;
  logic [2:0]    tmr_address;
  logic          tmr_chipselect;
  logic          tmr_write_n;
  logic [15:0]   tmr_writedata;
  logic [15:0]   tmr_readdata;
  logic          tmr_irq;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  timer_sequencer #(.TICK_W(TW)) dut (
    .clk(clk), .reset(reset), .start_req(start_req), .period(period),
    .stop_req(stop_req), .snap_req(snap_req), .busy(busy), .running(running),
    .tick(tick), .tick_count(tick_count), .snap_valid(snap_valid), .snap_value(snap_value),
    .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect), .tmr_write_n(tmr_write_n),
    .tmr_writedata(tmr_writedata), .tmr_readdata(tmr_readdata), .tmr_irq(tmr_irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Interval timer model: down-counter reloaded from period, timeout every period+1 clocks,
  // period writes reload and stop, START in control wins, registered reads.
  logic [31:0] m_period = 32'd0;
  logic [31:0] m_cnt = 32'd0;
  logic [31:0] m_snap = 32'd0;
  logic        m_run = 1'b0;
  logic        m_cont = 1'b0;
  logic        m_ito = 1'b0;
  logic        m_to = 1'b0;
  logic [15:0] m_rd = 16'd0;

  assign tmr_irq      = m_to & m_ito;
  assign tmr_readdata = m_rd;

  always @(posedge clk) begin
    if (m_run) begin
      if (m_cnt == 32'd0) begin
        m_to  <= 1'b1;
        m_cnt <= m_period;
        if (!m_cont) m_run <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 32'd1;
      end
    end
    if (tmr_chipselect && !tmr_write_n) begin
      case (tmr_address)
        3'd0: m_to <= 1'b0;
        3'd1: begin
          if (tmr_writedata[3]) m_run <= 1'b0;
          if (tmr_writedata[2]) m_run <= 1'b1;
          m_cont <= tmr_writedata[1];
          m_ito  <= tmr_writedata[0];
        end
        3'd2: begin
          m_period[15:0] <= tmr_writedata;
          m_cnt <= {m_period[31:16], tmr_writedata};
          m_run <= 1'b0;
        end
        3'd3: begin
          m_period[31:16] <= tmr_writedata;
          m_cnt <= {tmr_writedata, m_period[15:0]};
          m_run <= 1'b0;
        end
        3'd4: m_snap <= m_cnt;
        default: ;
      endcase
    end
    if (tmr_chipselect && tmr_write_n) begin
      m_rd <= (tmr_address == 3'd4) ? m_snap[15:0] :
              (tmr_address == 3'd5) ? m_snap[31:16] : 16'd0;
    end
  end

  function automatic logic [20:0] busv();
    return {tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata};
  endfunction

  function automatic logic [20:0] wr_v(input logic [2:0] a, input logic [15:0] d);
    return {1'b1, 1'b0, a, d};
  endfunction

  function automatic logic [20:0] rd_v(input logic [2:0] a);
    return {1'b1, 1'b1, a, 16'd0};
  endfunction

  localparam logic [20:0] IDLE_V = {1'b0, 1'b1, 3'd0, 16'd0};

  task automatic wait_tick(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tick) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  // Drives a start request at the current negedge and follows the three programming writes.
  task automatic do_start(input logic [31:0] p, input string tag, output int ctrl_cyc);
    period = p;
    start_req = 1'b1;
    @(negedge clk);
    start_req = 1'b0;
    checks++;
    if (busv() !== wr_v(3'd2, p[15:0])) begin
      failures++; $display("[TB] FAIL %s_wr_pl: got %h, want %h", tag, busv(), wr_v(3'd2, p[15:0]));
    end
    @(negedge clk);
    checks++;
    if (busv() !== wr_v(3'd3, p[31:16])) begin
      failures++; $display("[TB] FAIL %s_wr_ph: got %h, want %h", tag, busv(), wr_v(3'd3, p[31:16]));
    end
    @(negedge clk);
    checks++;
    if (busv() !== wr_v(3'd1, 16'h0007)) begin
      failures++; $display("[TB] FAIL %s_wr_ctrl: got %h, want %h", tag, busv(), wr_v(3'd1, 16'h0007));
    end
    ctrl_cyc = cyc;
    @(negedge clk);
    checks++;
    if ({running, busy, tick_count} !== {1'b1, 1'b0, {TW{1'b0}}}) begin
      failures++; $display("[TB] FAIL %s_run: got run=%b busy=%b cnt=%h, want 1 0 0", tag, running, busy, tick_count);
    end
  endtask

  task automatic do_stop();
    stop_req = 1'b1;
    @(negedge clk);
    stop_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busv() !== IDLE_V) begin
      failures++; $display("[TB] FAIL reset_bus: got %h, want %h", busv(), IDLE_V);
    end
    checks++;
    if ({busy, running, tick, snap_valid, tick_count, snap_value} !== '0) begin
      failures++; $display("[TB] FAIL reset_status: got %b%b%b%b %h %h, want all 0", busy, running, tick, snap_valid, tick_count, snap_value);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_start();
    int c;
    bit f;
    do_start(32'd9, "start", c);
    for (int k = 1; k <= 3; k++) begin
      wait_tick(30, f);
      checks++;
      if (!f || (cyc - c) !== 12 + 10 * (k - 1)) begin
        failures++; $display("[TB] FAIL start_tick%0d_time: got found=%b offset %0d, want offset %0d", k, f, cyc - c, 12 + 10 * (k - 1));
      end
      @(negedge clk);
      checks++;
      if (tick_count !== TW'(k)) begin
        failures++; $display("[TB] FAIL start_tick%0d_count: got %0d, want %0d", k, tick_count, k);
      end
    end
  endtask

  task automatic test_stop();
    int seen;
    stop_req = 1'b1;
    @(negedge clk);
    stop_req = 1'b0;
    checks++;
    if (busv() !== wr_v(3'd1, 16'h0008)) begin
      failures++; $display("[TB] FAIL stop_wr: got %h, want %h", busv(), wr_v(3'd1, 16'h0008));
    end
    @(negedge clk);
    checks++;
    if (busv() !== wr_v(3'd0, 16'h0000)) begin
      failures++; $display("[TB] FAIL stop_clr: got %h, want %h", busv(), wr_v(3'd0, 16'h0000));
    end
    @(negedge clk);
    checks++;
    if ({busy, running, busv()} !== {2'b00, IDLE_V}) begin
      failures++; $display("[TB] FAIL stop_idle: got busy=%b run=%b bus=%h, want 0 0 %h", busy, running, busv(), IDLE_V);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (tick) seen++;
    end
    checks++;
    if (seen !== 0 || tick_count !== TW'(3)) begin
      failures++; $display("[TB] FAIL stop_quiet: got ticks=%0d cnt=%0d, want 0 3", seen, tick_count);
    end
  endtask

  task automatic test_snapshot();
    int c;
    do_start(32'h0001_86A0, "snap", c);
    repeat (4) @(negedge clk);
    snap_req = 1'b1;
    @(negedge clk);
    snap_req = 1'b0;
    checks++;
    if (busv() !== wr_v(3'd4, 16'h0000)) begin
      failures++; $display("[TB] FAIL snap_wr: got %h, want %h", busv(), wr_v(3'd4, 16'h0000));
    end
    @(negedge clk);
    checks++;
    if (busv() !== rd_v(3'd4)) begin
      failures++; $display("[TB] FAIL snap_rl: got %h, want %h", busv(), rd_v(3'd4));
    end
    @(negedge clk);
    checks++;
    if (busv() !== rd_v(3'd5)) begin
      failures++; $display("[TB] FAIL snap_rh: got %h, want %h", busv(), rd_v(3'd5));
    end
    @(negedge clk);
    checks++;
    if ({snap_valid, busv()} !== {1'b0, IDLE_V}) begin
      failures++; $display("[TB] FAIL snap_done: got valid=%b bus=%h, want 0 %h", snap_valid, busv(), IDLE_V);
    end
    @(negedge clk);
    // Capture happens 5 decrements after the counter was loaded with 100000.
    checks++;
    if ({snap_valid, snap_value} !== {1'b1, 32'h0001_869B}) begin
      failures++; $display("[TB] FAIL snap_value: got valid=%b value=%h, want 1 0001869b", snap_valid, snap_value);
    end
    checks++;
    if ({snap_value[31:16], running, busy} !== {16'h0001, 2'b10}) begin
      failures++; $display("[TB] FAIL snap_return: got hi=%h run=%b busy=%b, want 0001 1 0", snap_value[31:16], running, busy);
    end
    @(negedge clk);
    checks++;
    if (snap_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL snap_pulse: got %b, want 0", snap_valid);
    end
    do_stop();
  endtask

  task automatic test_irq_collision();
    int c;
    int seen;
    do_start(32'd9, "coll", c);
    repeat (10) @(negedge clk);
    checks++;
    if ({tmr_irq, running, busy} !== 3'b110) begin
      failures++; $display("[TB] FAIL coll_setup: got irq=%b run=%b busy=%b, want 1 1 0", tmr_irq, running, busy);
    end
    stop_req = 1'b1;
    snap_req = 1'b1;
    @(negedge clk);
    stop_req = 1'b0;
    snap_req = 1'b0;
    checks++;
    if ({tick, busv()} !== {1'b0, wr_v(3'd1, 16'h0008)}) begin
      failures++; $display("[TB] FAIL coll_stop_wr: got tick=%b bus=%h, want 0 %h", tick, busv(), wr_v(3'd1, 16'h0008));
    end
    @(negedge clk);
    checks++;
    if ({tick, busv()} !== {1'b0, wr_v(3'd0, 16'h0000)}) begin
      failures++; $display("[TB] FAIL coll_stop_clr: got tick=%b bus=%h, want 0 %h", tick, busv(), wr_v(3'd0, 16'h0000));
    end
    @(negedge clk);
    checks++;
    if ({tmr_irq, busy, running, tick_count} !== {3'b000, {TW{1'b0}}}) begin
      failures++; $display("[TB] FAIL coll_idle: got irq=%b busy=%b run=%b cnt=%0d, want 0 0 0 0", tmr_irq, busy, running, tick_count);
    end
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (tick || snap_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++; $display("[TB] FAIL coll_quiet: got %0d tick/snap pulses, want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    int c;
    int c2;
    int t1;
    bit f;
    do_start(32'd9, "b2b_a", c);
    wait_tick(30, f);
    @(negedge clk);
    checks++;
    if (!f || tick_count !== TW'(1)) begin
      failures++; $display("[TB] FAIL b2b_first: got found=%b cnt=%0d, want 1 1", f, tick_count);
    end
    do_start(32'd19, "b2b_b", c2);
    wait_tick(40, f);
    t1 = cyc;
    checks++;
    if (!f || (t1 - c2) !== 22) begin
      failures++; $display("[TB] FAIL b2b_tick1: got found=%b offset %0d, want offset 22", f, t1 - c2);
    end
    wait_tick(40, f);
    checks++;
    if (!f || (cyc - t1) !== 20) begin
      failures++; $display("[TB] FAIL b2b_spacing: got found=%b spacing %0d, want 20", f, cyc - t1);
    end
    @(negedge clk);
    do_stop();
  endtask

  task automatic test_wrap();
    int c;
    bit f;
    logic [TW-1:0] exp_cnt;
    do_start(32'd7, "wrap", c);
    for (int k = 1; k <= 17; k++) begin
      wait_tick(20, f);
      @(negedge clk);
      exp_cnt = TW'(k);
      checks++;
      if (!f || tick_count !== exp_cnt) begin
        failures++; $display("[TB] FAIL wrap_cnt%0d: got found=%b cnt=%h, want %h", k, f, tick_count, exp_cnt);
      end
    end
  endtask

  task automatic test_reset_mid();
    period = 32'h0000_0100;
    start_req = 1'b1;
    @(negedge clk);
    start_req = 1'b0;
    @(negedge clk);
    checks++;
    if (busv() !== wr_v(3'd3, 16'h0000)) begin
      failures++; $display("[TB] FAIL rmid_wr_ph: got %h, want %h", busv(), wr_v(3'd3, 16'h0000));
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busv() !== IDLE_V) begin
      failures++; $display("[TB] FAIL rmid_bus: got %h, want %h", busv(), IDLE_V);
    end
    checks++;
    if ({busy, running, tick, snap_valid, tick_count, snap_value} !== '0) begin
      failures++; $display("[TB] FAIL rmid_status: got %b%b%b%b %h %h, want all 0", busy, running, tick, snap_valid, tick_count, snap_value);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_snap_idle();
    snap_req = 1'b1;
    @(negedge clk);
    snap_req = 1'b0;
    checks++;
    if (busv() !== wr_v(3'd4, 16'h0000)) begin
      failures++; $display("[TB] FAIL sidle_wr: got %h, want %h", busv(), wr_v(3'd4, 16'h0000));
    end
    repeat (4) @(negedge clk);
    // Timer was left stopped holding the low period half just written (0x0100).
    checks++;
    if ({snap_valid, snap_value, running, busy} !== {1'b1, 32'h0000_0100, 2'b00}) begin
      failures++; $display("[TB] FAIL sidle_value: got valid=%b value=%h run=%b busy=%b, want 1 00000100 0 0", snap_valid, snap_value, running, busy);
    end
    @(negedge clk);
    checks++;
    if ({snap_valid, busy} !== 2'b00) begin
      failures++; $display("[TB] FAIL sidle_after: got valid=%b busy=%b, want 0 0", snap_valid, busy);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_stop();
    test_snapshot();
    test_irq_collision();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    test_snap_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
